// File: rtl/instruction_decode_stage_pkg.sv
// rtl/instruction_decode_stage_pkg.sv - opcode/ALU encodings, field positions and op decode helper
package instruction_decode_stage_pkg;

  localparam int FIELD_W = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [5:0] OP_AND = 6'b000000;
  localparam logic [5:0] OP_OR  = 6'b000001;
  localparam logic [5:0] OP_ADD = 6'b000010;
  localparam logic [5:0] OP_SUB = 6'b000110;
  localparam logic [5:0] OP_SLT = 6'b000111;
  localparam logic [5:0] OP_NOR = 6'b001100;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       illegal;
  } op_dec_t;

  // Legal ops carry their ALU code in op[3:0]; anything else falls back to ADD.
  function automatic op_dec_t decode_op(input logic [5:0] op);
    op_dec_t d;
    d.alu_ctrl = op[3:0];
    d.illegal  = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: d.illegal = 1'b0;
      default: begin
        d.alu_ctrl = ALU_ADD;
        d.illegal  = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// rtl/instruction_decode_stage_if.sv - fetch/write-back inputs and decoded outputs of the decode stage
interface instruction_decode_stage_if #(
  parameter int DATA_W = 32
);
  import instruction_decode_stage_pkg::*;

  logic [31:0]        INSTRUCTION;
  logic               ins_valid;
  logic               stall;
  logic               wb_en;
  logic [FIELD_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;

  logic [FIELD_W-1:0] ReadReg1;
  logic [FIELD_W-1:0] ReadReg2;
  logic [FIELD_W-1:0] WriteReg;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [3:0]         alu_ctrl;
  logic               id_valid;
  logic               illegal_op;

  modport master (
    output INSTRUCTION, ins_valid, stall, wb_en, wb_addr, wb_data,
    input  ReadReg1, ReadReg2, WriteReg, rs_data, rt_data, alu_ctrl, id_valid, illegal_op
  );

  modport slave (
    input  INSTRUCTION, ins_valid, stall, wb_en, wb_addr, wb_data,
    output ReadReg1, ReadReg2, WriteReg, rs_data, rt_data, alu_ctrl, id_valid, illegal_op
  );
endinterface

// File: rtl/instruction_decode_stage_reg_file.sv
// rtl/instruction_decode_stage_reg_file.sv - 2 async read / 1 sync write register file with sync clear
module instruction_decode_stage_reg_file
  import instruction_decode_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [FIELD_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [FIELD_W-1:0] raddr1,
  input  logic [FIELD_W-1:0] raddr2,
  output logic [DATA_W-1:0]  rdata1,
  output logic [DATA_W-1:0]  rdata2
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              zero1;
  logic              zero2;
  logic              wr_blocked;

  assign wr_blocked = (ZERO_REG != 0) && (waddr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && !wr_blocked) begin
      regs[waddr] <= wdata;
    end
  end

  assign zero1  = (ZERO_REG != 0) && (raddr1 == '0);
  assign zero2  = (ZERO_REG != 0) && (raddr2 == '0);
  assign rdata1 = zero1 ? '0 : regs[raddr1];
  assign rdata2 = zero2 ? '0 : regs[raddr2];

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - decode stage: field split, operand read with write-back bypass, output registers
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input logic                       CLK,
  input logic                       RESET,
  instruction_decode_stage_if.slave ifc
);

  logic [5:0]         op_f;
  logic [FIELD_W-1:0] rs_f;
  logic [FIELD_W-1:0] rt_f;
  logic [FIELD_W-1:0] rd_f;
  logic [DATA_W-1:0]  rf_rs;
  logic [DATA_W-1:0]  rf_rt;
  logic [DATA_W-1:0]  rs_next;
  logic [DATA_W-1:0]  rt_next;
  logic               wb_live;
  op_dec_t            dec;
  logic               unused_low_bits;

  logic [FIELD_W-1:0] read_reg1_q;
  logic [FIELD_W-1:0] read_reg2_q;
  logic [FIELD_W-1:0] write_reg_q;
  logic [DATA_W-1:0]  rs_data_q;
  logic [DATA_W-1:0]  rt_data_q;
  logic [3:0]         alu_ctrl_q;
  logic               id_valid_q;
  logic               illegal_q;

  assign op_f = ifc.INSTRUCTION[OP_HI:OP_LO];
  assign rs_f = ifc.INSTRUCTION[RS_HI:RS_LO];
  assign rt_f = ifc.INSTRUCTION[RT_HI:RT_LO];
  assign rd_f = ifc.INSTRUCTION[RD_HI:RD_LO];
  assign unused_low_bits = ^ifc.INSTRUCTION[10:0];
  assign dec  = decode_op(op_f);

  instruction_decode_stage_reg_file #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) u_reg_file (
    .clk   (CLK),
    .rst   (RESET),
    .we    (ifc.wb_en),
    .waddr (ifc.wb_addr),
    .wdata (ifc.wb_data),
    .raddr1(rs_f),
    .raddr2(rt_f),
    .rdata1(rf_rs),
    .rdata2(rf_rt)
  );

  // A same-edge write to a hard-wired zero register must not leak through the bypass.
  assign wb_live = ifc.wb_en && !((ZERO_REG != 0) && (ifc.wb_addr == '0));
  assign rs_next = (wb_live && (ifc.wb_addr == rs_f)) ? ifc.wb_data : rf_rs;
  assign rt_next = (wb_live && (ifc.wb_addr == rt_f)) ? ifc.wb_data : rf_rt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      read_reg1_q <= '0;
      read_reg2_q <= '0;
      write_reg_q <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      alu_ctrl_q  <= '0;
      id_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (!ifc.stall) begin
      id_valid_q <= ifc.ins_valid;
      if (ifc.ins_valid) begin
        read_reg1_q <= rs_f;
        read_reg2_q <= rt_f;
        write_reg_q <= rd_f;
        rs_data_q   <= rs_next;
        rt_data_q   <= rt_next;
        alu_ctrl_q  <= dec.alu_ctrl;
        illegal_q   <= dec.illegal;
      end
    end
  end

  assign ifc.ReadReg1   = read_reg1_q;
  assign ifc.ReadReg2   = read_reg2_q;
  assign ifc.WriteReg   = write_reg_q;
  assign ifc.rs_data    = rs_data_q;
  assign ifc.rt_data    = rt_data_q;
  assign ifc.alu_ctrl   = alu_ctrl_q;
  assign ifc.id_valid   = id_valid_q;
  assign ifc.illegal_op = illegal_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - scoreboard bench for instruction_decode_stage
module tb_instruction_decode_stage;
  import instruction_decode_stage_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  instruction_decode_stage_if #(.DATA_W(32)) ifc ();

  instruction_decode_stage #(
    .DATA_W  (32),
    .NREGS   (32),
    .ZERO_REG(1)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .ifc  (ifc)
  );

  typedef struct {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'h5A5};
  endfunction

  function automatic exp_t ex(logic [4:0] r1, logic [4:0] r2, logic [4:0] wr,
                              logic [31:0] a, logic [31:0] b, logic [3:0] alu, logic ill);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.wr = wr; e.a = a; e.b = b; e.alu = alu; e.ill = ill;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_ReadReg1"}, 32'(ifc.ReadReg1), 32'd0);
    chk({tag, "_ReadReg2"}, 32'(ifc.ReadReg2), 32'd0);
    chk({tag, "_WriteReg"}, 32'(ifc.WriteReg), 32'd0);
    chk({tag, "_rs_data"}, ifc.rs_data, 32'd0);
    chk({tag, "_rt_data"}, ifc.rt_data, 32'd0);
    chk({tag, "_alu_ctrl"}, 32'(ifc.alu_ctrl), 32'd0);
    chk({tag, "_id_valid"}, 32'(ifc.id_valid), 32'd0);
    chk({tag, "_illegal_op"}, 32'(ifc.illegal_op), 32'd0);
  endtask

  // Monitor: an instruction accepted at a posedge must show up after that edge.
  initial begin
    bit   acc;
    exp_t e;
    forever begin
      @(posedge CLK);
      acc = mon_en && ifc.ins_valid && !ifc.stall && !RESET;
      @(negedge CLK);
      if (acc) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("ReadReg1", 32'(ifc.ReadReg1), 32'(e.r1));
          chk("ReadReg2", 32'(ifc.ReadReg2), 32'(e.r2));
          chk("WriteReg", 32'(ifc.WriteReg), 32'(e.wr));
          chk("rs_data", ifc.rs_data, e.a);
          chk("rt_data", ifc.rt_data, e.b);
          chk("alu_ctrl", 32'(ifc.alu_ctrl), 32'(e.alu));
          chk("illegal_op", 32'(ifc.illegal_op), 32'(e.ill));
          chk("id_valid", 32'(ifc.id_valid), 32'd1);
        end
      end
    end
  end

  task automatic idle();
    ifc.ins_valid = 1'b0;
    ifc.stall     = 1'b0;
    ifc.wb_en     = 1'b0;
  endtask

  task automatic issue(logic [31:0] ins, exp_t e);
    ifc.INSTRUCTION = ins;
    ifc.ins_valid   = 1'b1;
    q.push_back(e);
    @(negedge CLK);
    ifc.ins_valid = 1'b0;
  endtask

  task automatic wb(logic [4:0] a, logic [31:0] d);
    ifc.wb_en   = 1'b1;
    ifc.wb_addr = a;
    ifc.wb_data = d;
    @(negedge CLK);
    ifc.wb_en = 1'b0;
  endtask

  initial begin
    idle();
    ifc.INSTRUCTION = 32'h0;
    ifc.wb_addr     = 5'd0;
    ifc.wb_data     = 32'h0;
    RESET           = 1'b1;
    repeat (2) @(negedge CLK);
    chk_zero_outputs("por");
    RESET = 1'b0;

    // Random activity, then reset asserted alongside ins_valid/wb_en.
    for (int i = 0; i < 12; i++) begin
      ifc.INSTRUCTION = $urandom;
      ifc.ins_valid   = 1'($urandom_range(0, 1));
      ifc.stall       = 1'($urandom_range(0, 1));
      ifc.wb_en       = 1'b1;
      ifc.wb_addr     = 5'($urandom_range(0, 31));
      ifc.wb_data     = $urandom | 32'h1;
      @(negedge CLK);
    end
    ifc.ins_valid   = 1'b1;
    ifc.stall       = 1'b0;
    ifc.INSTRUCTION = mk(OP_NOR, 5'd3, 5'd4, 5'd5);
    RESET           = 1'b1;
    repeat (2) @(negedge CLK);
    chk_zero_outputs("rst");
    RESET = 1'b0;
    idle();
    @(negedge CLK);
    mon_en = 1'b1;

    // Every register reads 0 after reset.
    for (int k = 0; k < 16; k++)
      issue(mk(OP_ADD, 5'(2 * k), 5'(2 * k + 1), 5'(k)),
            ex(5'(2 * k), 5'(2 * k + 1), 5'(k), 32'd0, 32'd0, ALU_ADD, 1'b0));

    wb(5'd0, 32'd5);
    wb(5'd1, 32'd7);
    issue(32'h08011000, ex(5'd0, 5'd1, 5'd2, 32'd0, 32'd7, ALU_ADD, 1'b0));

    // SUB 0x19895800: rs=12, rt=9, rd=11; same-edge write of r9 bypasses to rt.
    ifc.wb_en   = 1'b1;
    ifc.wb_addr = 5'd9;
    ifc.wb_data = 32'hDEAD_BEEF;
    issue(32'h19895800, ex(5'd12, 5'd9, 5'd11, 32'd0, 32'hDEAD_BEEF, ALU_SUB, 1'b0));
    ifc.wb_en = 1'b0;

    // NOR 0x31F08800: rs=15, rt=16, rd=17; then a 3-cycle stall with a pending OR.
    wb(5'd15, 32'h0000_1111);
    wb(5'd16, 32'h0000_2222);
    issue(32'h31F08800, ex(5'd15, 5'd16, 5'd17, 32'h1111, 32'h2222, ALU_NOR, 1'b0));
    ifc.stall       = 1'b1;
    ifc.ins_valid   = 1'b1;
    ifc.INSTRUCTION = mk(OP_OR, 5'd9, 5'd1, 5'd3);
    ifc.wb_en       = 1'b1;
    ifc.wb_addr     = 5'd1;
    ifc.wb_data     = 32'h0000_0077;
    for (int s = 0; s < 3; s++) begin
      @(negedge CLK);
      ifc.wb_en = 1'b0;
      chk("stall_ReadReg1", 32'(ifc.ReadReg1), 32'd15);
      chk("stall_WriteReg", 32'(ifc.WriteReg), 32'd17);
      chk("stall_rs_data", ifc.rs_data, 32'h1111);
      chk("stall_rt_data", ifc.rt_data, 32'h2222);
      chk("stall_alu_ctrl", 32'(ifc.alu_ctrl), 32'(ALU_NOR));
      chk("stall_id_valid", 32'(ifc.id_valid), 32'd1);
    end
    ifc.stall = 1'b0;
    q.push_back(ex(5'd9, 5'd1, 5'd3, 32'hDEAD_BEEF, 32'h77, ALU_OR, 1'b0));
    @(negedge CLK);
    ifc.ins_valid = 1'b0;
    @(negedge CLK);
    chk("idle_id_valid", 32'(ifc.id_valid), 32'd0);
    chk("idle_alu_hold", 32'(ifc.alu_ctrl), 32'(ALU_OR));
    chk("idle_rs_hold", ifc.rs_data, 32'hDEAD_BEEF);

    // Illegal ops fall back to ADD control.
    issue(mk(6'b111111, 5'd1, 5'd2, 5'd4), ex(5'd1, 5'd2, 5'd4, 32'h77, 32'd0, ALU_ADD, 1'b1));
    issue(mk(6'b000011, 5'd9, 5'd1, 5'd8), ex(5'd9, 5'd1, 5'd8, 32'hDEAD_BEEF, 32'h77, ALU_ADD, 1'b1));

    // r0 ignores writes, including a same-edge write during decode.
    wb(5'd0, 32'hFFFF_FFFF);
    issue(mk(OP_AND, 5'd0, 5'd0, 5'd5), ex(5'd0, 5'd0, 5'd5, 32'd0, 32'd0, ALU_AND, 1'b0));
    ifc.wb_en   = 1'b1;
    ifc.wb_addr = 5'd0;
    ifc.wb_data = 32'hFFFF_FFFF;
    issue(mk(OP_SLT, 5'd0, 5'd1, 5'd6), ex(5'd0, 5'd1, 5'd6, 32'd0, 32'h77, ALU_SLT, 1'b0));
    ifc.wb_en = 1'b0;

    // Back-to-back stream of all six legal ops.
    issue(mk(OP_ADD, 5'd1, 5'd9, 5'd20), ex(5'd1, 5'd9, 5'd20, 32'h77, 32'hDEAD_BEEF, 4'h2, 1'b0));
    issue(mk(OP_AND, 5'd1, 5'd9, 5'd21), ex(5'd1, 5'd9, 5'd21, 32'h77, 32'hDEAD_BEEF, 4'h0, 1'b0));
    issue(mk(OP_OR,  5'd1, 5'd9, 5'd22), ex(5'd1, 5'd9, 5'd22, 32'h77, 32'hDEAD_BEEF, 4'h1, 1'b0));
    issue(mk(OP_SUB, 5'd1, 5'd9, 5'd23), ex(5'd1, 5'd9, 5'd23, 32'h77, 32'hDEAD_BEEF, 4'h6, 1'b0));
    issue(mk(OP_SLT, 5'd1, 5'd9, 5'd24), ex(5'd1, 5'd9, 5'd24, 32'h77, 32'hDEAD_BEEF, 4'h7, 1'b0));
    issue(mk(OP_NOR, 5'd1, 5'd9, 5'd25), ex(5'd1, 5'd9, 5'd25, 32'h77, 32'hDEAD_BEEF, 4'hC, 1'b0));
    idle();

    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge CLK);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
